// File: rtl/acs_if.sv
// Bundle between the branch-metric source and the add-compare-select array.
// Handshake: in_valid carries one trellis step per cycle with no backpressure; out_valid pulses for one cycle per accepted step.
interface acs_if #(
  parameter int K    = 3,
  parameter int PM_W = 6,
  parameter int BM_W = 2
);
  localparam int N = 1 << (K - 1);

  logic                start;
  logic                in_valid;
  logic [4*BM_W-1:0]   bm;
  logic                out_valid;
  logic [N-1:0]        decision;
  logic [N*PM_W-1:0]   pm;
  logic [K-2:0]        min_state;
  logic                norm;

  modport master (
    output start, in_valid, bm,
    input  out_valid, decision, pm, min_state, norm
  );

  modport slave (
    input  start, in_valid, bm,
    output out_valid, decision, pm, min_state, norm
  );
endinterface

// File: rtl/acs_array.sv
// Radix-2 add-compare-select array for a rate-1/2 Viterbi decoder: one trellis
// step per cycle, saturating metrics with subtractive normalisation.
module acs_array #(
  parameter int K    = 3,
  parameter int G0   = 7,
  parameter int G1   = 5,
  parameter int PM_W = 6,
  parameter int BM_W = 2
) (
  input logic  clock,
  input logic  reset,
  acs_if.slave bus
);
  localparam int N = 1 << (K - 1);
  localparam int S = K - 1;
  localparam logic [K-1:0]    G0_K     = K'(G0);
  localparam logic [K-1:0]    G1_K     = K'(G1);
  localparam logic [PM_W:0]   PM_MAX_X = {1'b0, {PM_W{1'b1}}};
  localparam logic [PM_W-1:0] PM_MAX   = {PM_W{1'b1}};
  localparam logic [PM_W-1:0] HALF     = {1'b1, {(PM_W-1){1'b0}}};

  logic [PM_W-1:0] pm_q [N];
  logic [PM_W-1:0] pm_d [N];
  logic [PM_W-1:0] surv [N];
  logic [N-1:0]    dec_q, dec_d;
  logic [S-1:0]    min_q, min_d;
  logic            norm_q, norm_d;
  logic            ov_q;

  logic [S-1:0]    ns_v, p0, p1;
  logic [1:0]      sym_a, sym_b;
  logic [BM_W-1:0] bm_a, bm_b;
  logic [PM_W:0]   sum_a, sum_b;
  logic [PM_W-1:0] min_v;

  // Code symbol {c0,c1} emitted on the branch labelled r = {u, predecessor}.
  function automatic logic [1:0] code_sym(input logic [K-1:0] r);
    return {^(r & G0_K), ^(r & G1_K)};
  endfunction

  always_comb begin
    ns_v  = '0;
    p0    = '0;
    p1    = '0;
    sym_a = '0;
    sym_b = '0;
    bm_a  = '0;
    bm_b  = '0;
    sum_a = '0;
    sum_b = '0;
    dec_d = '0;
    for (int s = 0; s < N; s++) begin
      surv[s] = '0;
      pm_d[s] = '0;
    end

    for (int ns = 0; ns < N; ns++) begin
      ns_v  = S'(ns);
      p0    = {ns_v[S-2:0], 1'b0};
      p1    = {ns_v[S-2:0], 1'b1};
      sym_a = code_sym({ns_v[S-1], p0});
      sym_b = code_sym({ns_v[S-1], p1});
      bm_a  = bus.bm[sym_a*BM_W +: BM_W];
      bm_b  = bus.bm[sym_b*BM_W +: BM_W];
      sum_a = {1'b0, pm_q[p0]} + (PM_W+1)'(bm_a);
      sum_b = {1'b0, pm_q[p1]} + (PM_W+1)'(bm_b);
      if (sum_a > PM_MAX_X) sum_a = PM_MAX_X;
      if (sum_b > PM_MAX_X) sum_b = PM_MAX_X;
      // Ties resolve toward the even predecessor.
      if (sum_a <= sum_b) begin
        surv[ns]  = sum_a[PM_W-1:0];
        dec_d[ns] = 1'b0;
      end else begin
        surv[ns]  = sum_b[PM_W-1:0];
        dec_d[ns] = 1'b1;
      end
    end

    // Strict compare keeps the lowest index; a uniform offset cannot move it.
    min_v = surv[0];
    min_d = '0;
    for (int s = 1; s < N; s++) begin
      if (surv[s] < min_v) begin
        min_v = surv[s];
        min_d = S'(s);
      end
    end

    norm_d = min_v[PM_W-1];
    for (int s = 0; s < N; s++) begin
      pm_d[s] = norm_d ? (surv[s] - HALF) : surv[s];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < N; s++) pm_q[s] <= (s == 0) ? '0 : PM_MAX;
      dec_q  <= '0;
      min_q  <= '0;
      norm_q <= 1'b0;
      ov_q   <= 1'b0;
    end else if (bus.start) begin
      for (int s = 0; s < N; s++) pm_q[s] <= (s == 0) ? '0 : PM_MAX;
      dec_q  <= '0;
      min_q  <= '0;
      norm_q <= 1'b0;
      ov_q   <= 1'b0;
    end else if (bus.in_valid) begin
      pm_q   <= pm_d;
      dec_q  <= dec_d;
      min_q  <= min_d;
      norm_q <= norm_d;
      ov_q   <= 1'b1;
    end else begin
      ov_q   <= 1'b0;
    end
  end

  for (genvar gs = 0; gs < N; gs++) begin : g_pm_out
    assign bus.pm[gs*PM_W +: PM_W] = pm_q[gs];
  end

  assign bus.decision  = dec_q;
  assign bus.min_state = min_q;
  assign bus.norm      = norm_q;
  assign bus.out_valid = ov_q;
endmodule

// File: tb/tb_acs_array.sv
// Bench for acs_array (K=3, G0=7, G1=5): hand-computed directed steps plus a
// forward-trellis reference model feeding a scoreboard checked on out_valid.
module tb_acs_array;
  localparam int K   = 3;
  localparam int G0  = 7;
  localparam int G1  = 5;
  localparam int PMW = 6;
  localparam int BMW = 2;
  localparam int N   = 1 << (K - 1);
  localparam int S   = K - 1;
  localparam int EW  = N*PMW + N + S + 1;
  localparam int PMAX = (1 << PMW) - 1;
  localparam int HALF = 1 << (PMW - 1);

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   mpm [N];
  logic [EW-1:0] exp_q [$];

  acs_if #(.K(K), .PM_W(PMW), .BM_W(BMW)) bus ();

  acs_array #(.K(K), .G0(G0), .G1(G1), .PM_W(PMW), .BM_W(BMW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // ---------------- reference model ----------------
  function automatic void model_init();
    for (int s = 0; s < N; s++) mpm[s] = (s == 0) ? 0 : PMAX;
  endfunction

  function automatic void model_step(input logic [4*BMW-1:0] b);
    int sa [N];
    int sb [N];
    int nw [N];
    logic [N-1:0]     dec;
    logic [N*PMW-1:0] pk;
    int mn, mi, ns, r, j, sum;
    bit nz;
    for (int s = 0; s < N; s++) begin
      for (int u = 0; u < 2; u++) begin
        ns  = (u << (K - 2)) | (s >> 1);
        r   = (u << (K - 1)) | s;
        j   = (($countones(r & G0) % 2) * 2) + ($countones(r & G1) % 2);
        sum = mpm[s] + int'(b[j*BMW +: BMW]);
        if (sum > PMAX) sum = PMAX;
        if (s % 2 == 0) sa[ns] = sum;
        else            sb[ns] = sum;
      end
    end
    for (int n = 0; n < N; n++) begin
      if (sa[n] <= sb[n]) begin nw[n] = sa[n]; dec[n] = 1'b0; end
      else                begin nw[n] = sb[n]; dec[n] = 1'b1; end
    end
    mn = nw[0];
    for (int n = 1; n < N; n++) if (nw[n] < mn) mn = nw[n];
    nz = (mn >= HALF);
    mi = -1;
    for (int n = 0; n < N; n++) begin
      if (nz) nw[n] = nw[n] - HALF;
      mpm[n] = nw[n];
      pk[n*PMW +: PMW] = PMW'(nw[n]);
      if (mi < 0 && nw[n] == (nz ? mn - HALF : mn)) mi = n;
    end
    exp_q.push_back({pk, dec, S'(mi), nz});
  endfunction

  // ---------------- driver ----------------
  task automatic cycle(input logic v, input logic st, input logic [4*BMW-1:0] b);
    bus.in_valid = v;
    bus.start    = st;
    bus.bm       = b;
    if (st)     model_init();
    else if (v) model_step(b);
    @(posedge clock);
    #1;
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
  endtask

  task automatic check_hand(input string name, input logic [N*PMW-1:0] e_pm,
                            input logic [N-1:0] e_dec, input logic [S-1:0] e_min,
                            input logic e_norm, input logic e_ov);
    logic [EW:0] act, req;
    act = {bus.pm, bus.decision, bus.min_state, bus.norm, bus.out_valid};
    req = {e_pm, e_dec, e_min, e_norm, e_ov};
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got pm=%h dec=%b min=%0d norm=%b ov=%b, want pm=%h dec=%b min=%0d norm=%b ov=%b",
               name, bus.pm, bus.decision, bus.min_state, bus.norm, bus.out_valid,
               e_pm, e_dec, e_min, e_norm, e_ov);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [EW-1:0] act, req;
    if (!reset && bus.out_valid) begin
      act = {bus.pm, bus.decision, bus.min_state, bus.norm};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_unexpected: got out_valid with %h, want no output", act);
      end else begin
        req = exp_q.pop_front();
        if (act !== req) begin
          errors++;
          $display("FAIL scoreboard_step: got %h, want %h", act, req);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  localparam logic [N*PMW-1:0] PM_INIT = {6'd63, 6'd63, 6'd63, 6'd0};

  initial begin
    reset        = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    bus.bm       = '0;
    model_init();
    repeat (2) @(posedge clock);
    #1;
    check_hand("reset_state", PM_INIT, 4'b0000, 2'd0, 1'b0, 1'b0);
    reset = 1'b0;
    cycle(1'b0, 1'b0, '0);

    // bm j=0..3 = {0,1,1,2}
    cycle(1'b1, 1'b0, {2'd2, 2'd1, 2'd1, 2'd0});
    check_hand("first_step", {6'd63, 6'd2, 6'd63, 6'd0}, 4'b0000, 2'd0, 1'b0, 1'b1);
    cycle(1'b0, 1'b0, {2'd3, 2'd3, 2'd3, 2'd3});
    check_hand("idle_hold", {6'd63, 6'd2, 6'd63, 6'd0}, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Saturation: 63+3 must clamp to 63 rather than wrap to 2
    cycle(1'b0, 1'b1, '0);
    check_hand("start_init", PM_INIT, 4'b0000, 2'd0, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, {2'd3, 2'd3, 2'd3, 2'd0});
    check_hand("saturate", {6'd63, 6'd3, 6'd63, 6'd0}, 4'b0000, 2'd0, 1'b0, 1'b1);

    // Tie case: all branch metrics equal drive metrics together
    cycle(1'b0, 1'b1, '0);
    cycle(1'b1, 1'b0, {2'd1, 2'd1, 2'd1, 2'd1});
    check_hand("tie_step1", {6'd63, 6'd1, 6'd63, 6'd1}, 4'b0000, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, {2'd1, 2'd1, 2'd1, 2'd1});
    check_hand("tie_step2", {4{6'd2}}, 4'b0000, 2'd0, 1'b0, 1'b1);
    cycle(1'b1, 1'b0, {2'd1, 2'd1, 2'd1, 2'd1});
    check_hand("tie_step3", {4{6'd3}}, 4'b0000, 2'd0, 1'b0, 1'b1);

    // Normalisation: metrics climb by 2 per step, reach 32 at step 16
    cycle(1'b0, 1'b1, '0);
    for (int i = 1; i <= 17; i++) begin
      cycle(1'b1, 1'b0, 8'hAA);
      if (i == 15) check_hand("pre_norm", {4{6'd30}}, 4'b0000, 2'd0, 1'b0, 1'b1);
      if (i == 16) check_hand("norm_step", {4{6'd0}}, 4'b0000, 2'd0, 1'b1, 1'b1);
      if (i == 17) check_hand("post_norm", {4{6'd2}}, 4'b0000, 2'd0, 1'b0, 1'b1);
    end

    // start wins over a simultaneous step
    cycle(1'b1, 1'b1, 8'hFF);
    check_hand("start_over_valid", PM_INIT, 4'b0000, 2'd0, 1'b0, 1'b0);

    // Asynchronous reset mid-stream discards the in-flight step
    cycle(1'b1, 1'b0, 8'h1B);
    bus.in_valid = 1'b1;
    bus.bm       = 8'h5A;
    #2;
    reset = 1'b1;
    exp_q.delete();
    model_init();
    #1;
    check_hand("async_reset", PM_INIT, 4'b0000, 2'd0, 1'b0, 1'b0);
    @(posedge clock);
    #1;
    reset        = 1'b0;
    bus.in_valid = 1'b0;
    cycle(1'b0, 1'b0, '0);
    cycle(1'b1, 1'b0, {2'd2, 2'd1, 2'd1, 2'd0});
    check_hand("step0_after_reset", {6'd63, 6'd2, 6'd63, 6'd0}, 4'b0000, 2'd0, 1'b0, 1'b1);

    // Random stream with gaps, checked against the model by the scoreboard
    for (int i = 0; i < 1000; i++) begin
      cycle(($urandom_range(0, 3) != 0), 1'b0, 8'($urandom_range(0, 255)));
    end
    repeat (3) cycle(1'b0, 1'b0, '0);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d outstanding expectations, want 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
